pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It generalises the plain enable register (`param_reg`) into a back-pressure-aware stage. It sits between core pipeline stages (e.g. fetch→decode, decode→execute), so a stall from downstream does not need a combinational path back to upstream. Full throughput is one transfer per cycle with one cycle of latency.

## Interface
Parameters:
- `N`, default `word_width` (32): data width in bits.

Ports:
- `clk`  input  1  clock; all state updates on its rising edge.
- `rst`  input  1  reset; asynchronous, active-low (asserted when 0).
- `in_valid`  input  1  upstream presents `in_data`.
- `in_ready`  output  1  stage can accept; a function of registered state only.
- `in_data`  input  N  upstream payload.
- `out_valid`  output  1  `out_data` holds a valid entry.
- `out_ready`  input  1  downstream accepts `out_data`.
- `out_data`  output  N  head entry, driven directly from a register.
- `flush`  input  1  discard all held entries. Only effective when `PIPE_SKID_FLUSH_EN` is defined.
- `level`  output  2  current occupancy: 0, 1 or 2.

## Operation
- Storage:
  - main register `M`, which drives `out_data`;
  - skid register `S`.
- Handshakes:
  - input transfer = `in_valid & in_ready` at a rising edge;
  - output transfer = `out_valid & out_ready` at a rising edge.
- `in_valid` and `in_data` must stay stable until transferred. The block does not check this.
- States (encoded in `level`):
  - EMPTY (0): `out_valid`=0, `in_ready`=1.
  - HALF (1): `out_valid`=1, `in_ready`=1.
  - FULL (2): `out_valid`=1, `in_ready`=0.
- Transitions:
  - EMPTY, input transfer → HALF, `M`←`in_data`.
  - HALF, input and output transfer together → HALF, `M`←`in_data`.
  - HALF, input transfer only → FULL, `S`←`in_data`.
  - HALF, output transfer only → EMPTY.
  - FULL, output transfer → HALF, `M`←`S`.
  - No transfer in any state → state and data hold.
- Ordering is strictly FIFO; no entry is lost or duplicated.
- Reset (`rst`=0, asynchronous):
  - state EMPTY, `level`=0, `out_valid`=0, `out_data`=0, `S`=0;
  - `in_ready` is forced to 0 while `rst` is low and returns to 1 on the first cycle after deassertion.
- Reset mid-transfer: all held entries are discarded, and a handshake coincident with the reset assertion is void.

## Timing
- Latency: data accepted at edge k appears on `out_data` with `out_valid`=1 after edge k when the stage was EMPTY, or when HALF with a simultaneous output transfer.
- Throughput: with `out_ready` held at 1, the stage accepts and emits one item per cycle and stays in HALF.
- `in_ready` has no combinational dependence on `out_ready`, `in_valid` or `flush`.
- Back-pressure: when `out_ready` drops, at most one additional input is absorbed into `S`, then `in_ready` falls on the following cycle.
- Recovery: from FULL, an output transfer at edge k raises `in_ready` after edge k.

## Configuration
- Macro: `PIPE_SKID_FLUSH_EN`.
- Defined: `flush`=1 at a rising edge forces EMPTY and `level`=0, and sets `out_valid`=0 after that edge.
  - An input transfer in the same cycle is discarded.
  - An output transfer in the same cycle still counts as delivered to downstream.
  - `M` and `S` keep their stale values. `flush` has priority over all other transitions.
- Not defined: the `flush` port remains in the port list but is ignored. No flush logic is synthesised.

## Test plan
- Reset: assert `rst`=0 mid-stream in FULL with `M`=0xA, `S`=0xB → `out_valid`=0, `out_data`=0, `level`=0 immediately. `in_ready`=0 until release, then 1 on the next cycle.
- Streaming: `out_ready`=1, push 0x1..0x8 on consecutive cycles → `out_data` shows 0x1..0x8 one cycle later, no bubbles, `level` stays 1.
- Back-pressure: push 0x10, 0x11, 0x12 with `out_ready`=0 → `level` reaches 2, 0x12 is not accepted while `in_ready`=0. Raising `out_ready` emits 0x10, 0x11, 0x12 in order.
- Simultaneous events in HALF: `in_valid`=1 with 0x20 and output transfer of 0x1F at the same edge → `out_data`=0x20, `level`=1.
- Flush (macro defined): in FULL with 0x30/0x31, `flush`=1 plus `in_valid`=1 with 0x32 → `level`=0 and `out_valid`=0 next cycle. A later push of 0x33 is the next item out.
- Flush (macro undefined): same stimulus → `flush` has no effect, output order is 0x30, 0x31, 0x32.

Source files
------------

// File: rtl/pipe_skid_reg.sv
//------------------------------------------------------------------------------
// pipe_skid_reg
//
// Pipeline stage register with a valid/ready handshake and a two-entry skid
// buffer. in_ready comes only from registered state, so a downstream stall
// never forms a combinational path back to upstream. Full throughput is one
// transfer per cycle with one cycle of latency.
//
// Parameters:
//   N          data width in bits (default 32)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   in_valid   upstream presents in_data
//   in_ready   stage can accept (registered)
//   in_data    upstream payload [N-1:0]
//   out_valid  out_data holds a valid entry
//   out_ready  downstream accepts out_data
//   out_data   head entry, driven from the main register [N-1:0]
//   flush      discard all held entries (only with PIPE_SKID_FLUSH_EN)
//   level      occupancy: 0, 1 or 2
//
// Configuration macro:
//   PIPE_SKID_FLUSH_EN  when defined, flush empties the stage. When undefined
//                       the flush port is present but ignored.
//------------------------------------------------------------------------------
module pipe_skid_reg #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   input  logic         flush,
   output logic [1:0]   level
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [N-1:0]   r_m;
   logic [N-1:0]   r_s;
   logic           r_in_rdy;

   logic           w_in_xfer;
   logic           w_out_xfer;
   logic           w_ld_m_in;
   logic           w_ld_m_s;
   logic           w_ld_s;

`ifndef PIPE_SKID_FLUSH_EN
   logic           w_unused_flush;
   assign w_unused_flush = flush;
`endif

   assign w_in_xfer  = in_valid & r_in_rdy;
   assign w_out_xfer = out_valid & out_ready;

   // Next-state and load selection
   always_comb begin
      w_state_nxt = r_state;
      w_ld_m_in   = 1'b0;
      w_ld_m_s    = 1'b0;
      w_ld_s      = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_in_xfer) begin
               w_state_nxt = HALF;
               w_ld_m_in   = 1'b1;
            end
         end
         HALF: begin
            if (w_in_xfer && w_out_xfer) begin
               w_ld_m_in = 1'b1;
            end else if (w_in_xfer) begin
               w_state_nxt = FULL;
               w_ld_s      = 1'b1;
            end else if (w_out_xfer) begin
               w_state_nxt = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so no input can arrive alongside.
            if (w_out_xfer) begin
               w_state_nxt = HALF;
               w_ld_m_s    = 1'b1;
            end
         end
         default: begin
            w_state_nxt = EMPTY;
         end
      endcase
`ifdef PIPE_SKID_FLUSH_EN
      // Flush wins over everything; held data is left stale.
      if (flush) begin
         w_state_nxt = EMPTY;
         w_ld_m_in   = 1'b0;
         w_ld_m_s    = 1'b0;
         w_ld_s      = 1'b0;
      end
`endif
   end

   // State and data registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= EMPTY;
         r_in_rdy <= 1'b0;
         r_m      <= '0;
         r_s      <= '0;
      end else begin
         r_state  <= w_state_nxt;
         // Registered copy of "not full" so in_ready has no input dependence
         // and stays low for the whole reset period.
         r_in_rdy <= (w_state_nxt != FULL);
         if (w_ld_m_in) begin
            r_m <= in_data;
         end else if (w_ld_m_s) begin
            r_m <= r_s;
         end
         if (w_ld_s) begin
            r_s <= in_data;
         end
      end
   end

   assign in_ready  = r_in_rdy;
   assign out_valid = (r_state != EMPTY);
   assign out_data  = r_m;
   assign level     = r_state;

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

   localparam int N = 32;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;
   logic         flush;
   logic [1:0]   level;

   int total;
   int bad;

   pipe_skid_reg #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush),
      .level     (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [1:0] lv, input logic ov,
                            input logic ir, input logic [31:0] od);
      check({tag, "_level"}, 32'(level), 32'(lv));
      check({tag, "_ovld"}, 32'(out_valid), 32'(ov));
      check({tag, "_irdy"}, 32'(in_ready), 32'(ir));
      check({tag, "_odata"}, out_data, od);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;

      // Initial reset
      step();
      step();
      chk_state("rst0", 2'd0, 1'b0, 1'b0, 32'h0);
      rst = 1'b1;
      #1;
      check("rst0_rel_irdy", 32'(in_ready), 32'd0);
      step();
      check("rst0_after_irdy", 32'(in_ready), 32'd1);

      // Fill to FULL with 0xA / 0xB, then assert reset asynchronously
      in_valid = 1'b1; in_data = 32'hA;
      step();
      chk_state("fillA", 2'd1, 1'b1, 1'b1, 32'hA);
      in_data = 32'hB;
      step();
      chk_state("fillB", 2'd2, 1'b1, 1'b0, 32'hA);
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk_state("rst_async", 2'd0, 1'b0, 1'b0, 32'h0);
      step();
      rst = 1'b1;
      #1;
      check("rst1_rel_irdy", 32'(in_ready), 32'd0);
      step();
      check("rst1_after_irdy", 32'(in_ready), 32'd1);

      // Streaming 0x1..0x8 with out_ready held high
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_data = 32'(i);
         step();
         chk_state($sformatf("stream%0d", i), 2'd1, 1'b1, 1'b1, 32'(i));
      end
      in_valid = 1'b0;
      step();
      check("stream_drain_level", 32'(level), 32'd0);
      check("stream_drain_ovld", 32'(out_valid), 32'd0);

      // Back-pressure
      out_ready = 1'b0;
      in_valid  = 1'b1; in_data = 32'h10;
      step();
      chk_state("bp10", 2'd1, 1'b1, 1'b1, 32'h10);
      in_data = 32'h11;
      step();
      chk_state("bp11", 2'd2, 1'b1, 1'b0, 32'h10);
      in_data = 32'h12;
      step();
      chk_state("bp12_blocked", 2'd2, 1'b1, 1'b0, 32'h10);
      out_ready = 1'b1;
      step();
      chk_state("bp_out10", 2'd1, 1'b1, 1'b1, 32'h11);
      step();
      chk_state("bp_out11", 2'd1, 1'b1, 1'b1, 32'h12);
      in_valid = 1'b0;
      step();
      check("bp_out12_level", 32'(level), 32'd0);

      // Simultaneous input and output in HALF
      out_ready = 1'b0;
      in_valid  = 1'b1; in_data = 32'h1F;
      step();
      chk_state("sim1F", 2'd1, 1'b1, 1'b1, 32'h1F);
      out_ready = 1'b1; in_data = 32'h20;
      step();
      chk_state("sim20", 2'd1, 1'b1, 1'b1, 32'h20);
      in_valid = 1'b0;
      step();
      check("sim_drain_level", 32'(level), 32'd0);

      // Flush from FULL with a coincident input
      out_ready = 1'b0;
      in_valid  = 1'b1; in_data = 32'h30;
      step();
      in_data = 32'h31;
      step();
      chk_state("fl_full", 2'd2, 1'b1, 1'b0, 32'h30);
      in_data = 32'h32; flush = 1'b1;
      step();
      flush = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
      check("fl_level", 32'(level), 32'd0);
      check("fl_ovld", 32'(out_valid), 32'd0);
      check("fl_irdy", 32'(in_ready), 32'd1);
      in_data = 32'h33;
      step();
      chk_state("fl_next33", 2'd1, 1'b1, 1'b1, 32'h33);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      check("fl_drain_level", 32'(level), 32'd0);
`else
      chk_state("nofl_hold", 2'd2, 1'b1, 1'b0, 32'h30);
      out_ready = 1'b1;
      step();
      chk_state("nofl_out30", 2'd1, 1'b1, 1'b1, 32'h31);
      step();
      chk_state("nofl_out31", 2'd1, 1'b1, 1'b1, 32'h32);
      in_valid = 1'b0;
      step();
      check("nofl_drain_level", 32'(level), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
